// File: rtl/kcpsm_io_bridge.sv
// KCPSM3 port bridge: shadowed multi-byte output word with atomic commit,
// sticky read-to-clear event flags and a maskable interrupt request.
module kcpsm_io_bridge #(
    parameter int DATA_W = 16,
    parameter int NEVT   = 4
) (
    input  logic              CLK1,
    input  logic              arst,
    input  logic [7:0]        port_id,
    input  logic              write_strobe,
    input  logic              read_strobe,
    input  logic [7:0]        out_port,
    output logic [7:0]        in_port,
    output logic              interrupt,
    input  logic              interrupt_ack,
    input  logic [NEVT-1:0]   evt,
    output logic [DATA_W-1:0] value,
    output logic              value_valid,
    output logic [7:0]        led
);

    localparam int NB = DATA_W / 8;

    localparam logic [7:0] A_COMMIT = 8'h10;
    localparam logic [7:0] A_VALUE  = 8'h11;
    localparam logic [7:0] A_STATUS = 8'h20;
    localparam logic [7:0] A_MASK   = 8'h21;

    logic [DATA_W-1:0] shadow;
    logic [NEVT-1:0]   flags;
    logic [NEVT-1:0]   mask;
    logic [NEVT-1:0]   evt_d;
    logic [NEVT-1:0]   evt_rise;
    logic              int_req;
    logic              commit;
    logic              status_rd;
    logic              mask_wr;

    assign evt_rise  = evt & ~evt_d;
    assign commit    = write_strobe && (port_id == A_COMMIT);
    assign mask_wr   = write_strobe && (port_id == A_MASK);
    assign status_rd = read_strobe && (port_id == A_STATUS);

    always_ff @(posedge CLK1) begin
        if (arst) begin
            shadow      <= '0;
            value       <= '0;
            flags       <= '0;
            mask        <= '0;
            evt_d       <= '0;
            int_req     <= 1'b0;
            value_valid <= 1'b0;
        end else begin
            evt_d       <= evt;
            value_valid <= commit;
            if (commit)
                value <= shadow;
            if (write_strobe) begin
                for (int k = 0; k < NB; k++) begin
                    if (port_id == 8'(k))
                        shadow[8*k +: 8] <= out_port;
                end
            end
            if (mask_wr)
                mask <= out_port[NEVT-1:0];
            // A rise in the clearing cycle becomes the new flag state
            if (status_rd)
                flags <= evt_rise;
            else
                flags <= flags | evt_rise;
            if (|(evt_rise & mask))
                int_req <= 1'b1;
            else if (interrupt_ack)
                int_req <= 1'b0;
        end
    end

    always_comb begin
        in_port = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (port_id == 8'(k))
                in_port = shadow[8*k +: 8];
            if (port_id == A_VALUE + 8'(k))
                in_port = value[8*k +: 8];
        end
        if (port_id == A_STATUS)
            in_port[NEVT-1:0] = flags;
        if (port_id == A_MASK)
            in_port[NEVT-1:0] = mask;
    end

    assign interrupt = int_req;
    assign led       = value[7:0];

endmodule

// File: tb/tb_kcpsm_io_bridge.sv
// Bench for kcpsm_io_bridge (32-bit word, 4 events): directed scenarios
// followed by random port traffic, all checked against a byte-level model.
module tb_kcpsm_io_bridge;

    localparam int DW = 32;
    localparam int NE = 4;
    localparam int NB = DW / 8;

    logic          CLK1 = 1'b0;
    logic          arst = 1'b1;
    logic [7:0]    port_id = 8'h00;
    logic          write_strobe = 1'b0;
    logic          read_strobe = 1'b0;
    logic [7:0]    out_port = 8'h00;
    logic [7:0]    in_port;
    logic          interrupt;
    logic          interrupt_ack = 1'b0;
    logic [NE-1:0] evt = '0;
    logic [DW-1:0] value;
    logic          value_valid;
    logic [7:0]    led;

    int n_cmp = 0;
    int n_bad = 0;
    bit en = 1'b0;

    kcpsm_io_bridge #(.DATA_W(DW), .NEVT(NE)) dut (
        .CLK1(CLK1), .arst(arst), .port_id(port_id),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .out_port(out_port), .in_port(in_port), .interrupt(interrupt),
        .interrupt_ack(interrupt_ack), .evt(evt), .value(value),
        .value_valid(value_valid), .led(led)
    );

    always #5 CLK1 = ~CLK1;

    // Reference model: byte arrays updated once per clock edge
    logic [7:0]    m_sh  [NB];
    logic [7:0]    m_val [NB];
    logic [NE-1:0] m_fl, m_mask, m_prev, m_rise;
    logic          m_int, m_vv;

    always @(posedge CLK1) begin
        if (arst) begin
            for (int i = 0; i < NB; i++) begin
                m_sh[i]  = 8'h00;
                m_val[i] = 8'h00;
            end
            m_fl = '0; m_mask = '0; m_prev = '0;
            m_int = 1'b0; m_vv = 1'b0;
        end else begin
            m_rise = evt & ~m_prev;
            m_prev = evt;
            m_vv = write_strobe && port_id == 8'h10;
            if ((m_rise & m_mask) != 0) m_int = 1'b1;
            else if (interrupt_ack) m_int = 1'b0;
            if (read_strobe && port_id == 8'h20) m_fl = m_rise;
            else m_fl = m_fl | m_rise;
            if (write_strobe) begin
                if (port_id < NB) m_sh[port_id[1:0]] = out_port;
                if (port_id == 8'h10)
                    for (int i = 0; i < NB; i++) m_val[i] = m_sh[i];
                if (port_id == 8'h21) m_mask = out_port[NE-1:0];
            end
        end
    end

    function automatic logic [DW-1:0] m_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < NB; i++) w[8*i +: 8] = m_val[i];
        return w;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] p);
        logic [7:0] r = 8'h00;
        if (p < NB) r = m_sh[p[1:0]];
        else if (p >= 8'h11 && p < 8'h11 + NB) r = m_val[2'(p - 8'h11)];
        else if (p == 8'h20) r = 8'(m_fl);
        else if (p == 8'h21) r = 8'(m_mask);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK1) begin
        if (en) begin
            chk("in_port", 64'(in_port), 64'(m_read(port_id)));
            chk("interrupt", 64'(interrupt), 64'(m_int));
            chk("value", 64'(value), 64'(m_word()));
            chk("value_valid", 64'(value_valid), 64'(m_vv));
            chk("led", 64'(led), 64'(m_val[0]));
        end
    end

    task automatic tick();
        @(posedge CLK1);
        #1;
    endtask

    task automatic io(input bit w, input logic [7:0] p, input logic [7:0] d);
        write_strobe = w; port_id = p; out_port = d;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd_chk(input logic [7:0] p, input logic [7:0] e,
                          input string nm);
        read_strobe = 1'b1; port_id = p;
        @(negedge CLK1);
        chk(nm, 64'(in_port), 64'(e));
        tick();
        read_strobe = 1'b0;
    endtask

    logic [7:0] ports [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10,
                               8'h11, 8'h14, 8'h15, 8'h20, 8'h21, 8'h22};

    initial begin
        tick();
        tick();
        arst = 1'b0;
        en = 1'b1;
        chk("reset_value", 64'(value), 64'h0);
        chk("reset_int", 64'(interrupt), 64'h0);

        // Two shadow bytes then commit
        io(1, 8'h00, 8'h34);
        io(1, 8'h01, 8'h12);
        io(1, 8'h10, 8'hA5);
        chk("t1_value", 64'(value), 64'h1234);
        chk("t1_led", 64'(led), 64'h34);
        chk("t1_vv_hi", 64'(value_valid), 64'h1);
        tick();
        chk("t1_vv_lo", 64'(value_valid), 64'h0);

        // Shadow write without commit leaves the value alone
        io(1, 8'h00, 8'hFF);
        chk("t2_value", 64'(value), 64'h1234);
        rd_chk(8'h11, 8'h34, "t2_rd_val0");
        rd_chk(8'h00, 8'hFF, "t2_rd_sh0");

        // Two pulses collapse into one sticky flag
        evt[0] = 1'b1; tick(); evt[0] = 1'b0; tick();
        evt[0] = 1'b1; tick(); evt[0] = 1'b0; tick();
        rd_chk(8'h20, 8'h01, "t3_stat1");
        rd_chk(8'h20, 8'h00, "t3_stat2");

        // Masked interrupt held until acknowledge
        io(1, 8'h21, 8'hF1);
        rd_chk(8'h21, 8'h01, "t4_mask");
        chk("t4_int_idle", 64'(interrupt), 64'h0);
        evt[0] = 1'b1;
        tick();
        chk("t4_int_set", 64'(interrupt), 64'h1);
        tick(); tick();
        chk("t4_int_hold", 64'(interrupt), 64'h1);
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
        chk("t4_int_clr", 64'(interrupt), 64'h0);

        // Event coinciding with the clearing read survives
        evt[1] = 1'b1;
        rd_chk(8'h20, 8'h01, "t5_old");
        rd_chk(8'h20, 8'h02, "t5_kept");
        chk("t5_no_int", 64'(interrupt), 64'h0);
        evt = '0;
        tick();

        // Full 32-bit word then reset
        io(1, 8'h00, 8'h78);
        io(1, 8'h01, 8'h56);
        io(1, 8'h02, 8'h34);
        io(1, 8'h03, 8'h12);
        io(1, 8'h10, 8'h00);
        chk("t6_value", 64'(value), 64'h12345678);
        chk("t6_led", 64'(led), 64'h78);
        arst = 1'b1; tick(); arst = 1'b0;
        chk("t6_rst_value", 64'(value), 64'h0);
        chk("t6_rst_vv", 64'(value_valid), 64'h0);

        // Partially written shadow is discarded by reset
        io(1, 8'h00, 8'hAA);
        arst = 1'b1; tick(); arst = 1'b0;
        io(1, 8'h10, 8'h00);
        chk("rst_mid_value", 64'(value), 64'h0);

        for (int c = 0; c < 3000; c++) begin
            arst          = ($urandom_range(0, 299) == 0);
            port_id       = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                            : ports[$urandom_range(0, 11)];
            write_strobe  = ($urandom_range(0, 2) == 0);
            read_strobe   = ($urandom_range(0, 2) == 0);
            out_port      = 8'($urandom);
            interrupt_ack = ($urandom_range(0, 7) == 0);
            for (int b = 0; b < NE; b++)
                if ($urandom_range(0, 3) == 0) evt[b] = ~evt[b];
            tick();
        end
        arst = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0;
        tick();
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
